// File: rtl/por_reset_sequencer.sv
// -----------------------------------------------------------------------------
// por_reset_sequencer
//
// Always-on reset sequencer that sits directly behind the POR/IO ring. Once the
// core POR releases, it does the following:
//   - synchronises the pad reset;
//   - requires a run of clean cycles before releasing anything;
//   - releases the reset domains one at a time in ascending order, optionally
//     waiting for a per-domain ready acknowledge (with a timeout);
//   - on a software warm-reset request, re-asserts the domains in descending
//     order and then restarts the whole sequence.
//
// Ports
//   CLK_I          in   1        always-on clock
//   RST_N_I        in   1        async active-low reset (from POR_N_CORE_O)
//   EXT_RST_N_I    in   1        async pad reset, active-low, 2-FF synchronised
//   SW_RST_REQ_I   in   1        single-cycle warm-reset request (CLK_I domain)
//   STAGE_ACK_I    in   NSTAGES  per-domain ready acknowledge, async, 2-FF sync'd
//   STAGE_RST_N_O  out  NSTAGES  registered active-low domain resets
//   SEQ_BUSY_O     out  1        high in every state except DONE
//   SEQ_DONE_O     out  1        high only in DONE
//   TIMEOUT_O      out  1        sticky ack-timeout flag (cleared only by RST_N_I)
//   STAGE_IDX_O    out  3        current stage index
// -----------------------------------------------------------------------------
module por_reset_sequencer #(
    parameter int                 NSTAGES     = 4,
    parameter int                 STRETCH_CYC = 64,
    parameter int                 GAP_CYC     = 16,
    parameter logic [NSTAGES-1:0] ACK_MASK    = NSTAGES'(1),
    parameter int                 ACK_TIMEOUT = 1024
) (
    input  logic               CLK_I,
    input  logic               RST_N_I,
    input  logic               EXT_RST_N_I,
    input  logic               SW_RST_REQ_I,
    input  logic [NSTAGES-1:0] STAGE_ACK_I,
    output logic [NSTAGES-1:0] STAGE_RST_N_O,
    output logic               SEQ_BUSY_O,
    output logic               SEQ_DONE_O,
    output logic               TIMEOUT_O,
    output logic [2:0]         STAGE_IDX_O
);

    localparam int MAX_SG = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
    localparam int MAX_ALL = (MAX_SG > ACK_TIMEOUT) ? MAX_SG : ACK_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0]   STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST      = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0]         LAST_IDX     = 3'(NSTAGES - 1);
    localparam logic [NSTAGES-1:0] LAST_OH      = NSTAGES'(1) << (NSTAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_REL,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_FAULT,
        S_ASSERT
    } state_t;

    state_t             state_q;
    logic [2:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NSTAGES-1:0] stage_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;

    logic               ext_meta_q;
    logic               ext_sync_q;
    logic [NSTAGES-1:0] ack_meta_q;
    logic [NSTAGES-1:0] ack_sync_q;

    logic [NSTAGES-1:0] idx_oh;
    logic               ack_hit;
    logic               mask_hit;

    // Synchronisers reset to 0 so the FSM always sees "pad reset active"
    // until the pad level has been sampled twice after POR release.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
            ack_meta_q <= '0;
            ack_sync_q <= '0;
        end else begin
            ext_meta_q <= EXT_RST_N_I;
            ext_sync_q <= ext_meta_q;
            ack_meta_q <= STAGE_ACK_I;
            ack_sync_q <= ack_meta_q;
        end
    end

    // One-hot decode of the stage index keeps every per-stage select at
    // NSTAGES width, whatever NSTAGES is.
    always_comb begin
        idx_oh = '0;
        for (int i = 0; i < NSTAGES; i++) begin
            idx_oh[i] = (idx_q == 3'(i));
        end
    end

    assign ack_hit  = |(ack_sync_q & idx_oh);
    assign mask_hit = |(ACK_MASK & idx_oh);

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q   <= S_HOLD;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            stage_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (!ext_sync_q) begin
            // Pad reset overrides every state; the timeout flag survives it.
            state_q <= S_HOLD;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == STRETCH_LAST) begin
                        state_q <= S_REL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REL: begin
                    stage_q <= stage_q | idx_oh;
                    cnt_q   <= '0;
                    state_q <= mask_hit ? S_WAIT_ACK : S_GAP;
                end
                S_WAIT_ACK: begin
                    // Ack is tested first so a late ack on the final count
                    // still counts as success.
                    if (ack_hit) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= S_FAULT;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= S_REL;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE, S_FAULT: begin
                    if (SW_RST_REQ_I) begin
                        // The top stage is cleared on the entry edge itself.
                        stage_q <= stage_q & ~LAST_OH;
                        idx_q   <= LAST_IDX;
                        cnt_q   <= '0;
                        state_q <= (NSTAGES == 1) ? S_HOLD : S_ASSERT;
                    end else if (state_q == S_DONE) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        stage_q <= stage_q & ~(idx_oh >> 1);
                        idx_q   <= idx_q - 3'd1;
                        if (idx_q == 3'd1) begin
                            state_q <= S_HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                    idx_q   <= 3'd0;
                end
            endcase
        end
    end

    assign STAGE_RST_N_O = stage_q;
    assign SEQ_BUSY_O    = busy_q;
    assign SEQ_DONE_O    = done_q;
    assign TIMEOUT_O     = timeout_q;
    assign STAGE_IDX_O   = idx_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_por_reset_sequencer
//
// Directed bench for por_reset_sequencer with the default parameters
// (4 stages, stretch 64, gap 16, stage 0 acked, ack timeout 1024).
// -----------------------------------------------------------------------------
module tb_por_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ext_rst_n;
    logic       sw_req;
    logic [3:0] stage_ack;
    logic [3:0] stage_rst_n;
    logic       busy;
    logic       done;
    logic       tmo;
    logic [2:0] idx;

    int n_cmp;
    int n_fail;

    por_reset_sequencer dut (
        .CLK_I        (clk),
        .RST_N_I      (rst_n),
        .EXT_RST_N_I  (ext_rst_n),
        .SW_RST_REQ_I (sw_req),
        .STAGE_ACK_I  (stage_ack),
        .STAGE_RST_N_O(stage_rst_n),
        .SEQ_BUSY_O   (busy),
        .SEQ_DONE_O   (done),
        .TIMEOUT_O    (tmo),
        .STAGE_IDX_O  (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stage"}, 32'(stage_rst_n), 32'h0);
        check({tag, "_busy"},  32'(busy),        32'h1);
        check({tag, "_done"},  32'(done),        32'h0);
        check({tag, "_tmo"},   32'(tmo),         32'h0);
        check({tag, "_idx"},   32'(idx),         32'h0);
    endtask

    initial begin
        int k;
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        ext_rst_n = 1'b1;
        sw_req    = 1'b0;
        stage_ack = 4'b0001;

        // ---------------- Test 1: normal release with stage 0 acked
        step(3);
        check_reset_vals("rst");
        rst_n = 1'b1;                    // next edge is edge 1
        step(66);
        check("t1_s0_before", 32'(stage_rst_n), 32'h0);
        step(1);                         // edge 67
        check("t1_s0_rise", 32'(stage_rst_n), 32'h1);
        check("t1_idx0", 32'(idx), 32'h0);
        k = 0;
        while (stage_rst_n[1] !== 1'b1 && k < 60) begin
            step(1);
            k++;
        end
        check("t1_s1_window", 32'(k >= 18 && k <= 20), 32'h1);
        check("t1_s1_rise", 32'(stage_rst_n), 32'h3);
        step(16);
        check("t1_s2_before", 32'(stage_rst_n), 32'h3);
        step(1);
        check("t1_s2_rise", 32'(stage_rst_n), 32'h7);
        check("t1_idx2", 32'(idx), 32'h2);
        step(17);
        check("t1_s3_rise", 32'(stage_rst_n), 32'hF);
        step(15);
        check("t1_busy_pre_done", 32'(busy), 32'h1);
        check("t1_done_pre", 32'(done), 32'h0);
        step(1);
        check("t1_done", 32'(done), 32'h1);
        check("t1_busy_done", 32'(busy), 32'h0);
        stage_ack = 4'b0000;             // ack drop after release is ignored
        step(10);
        check("t1_done_hold", 32'(done), 32'h1);
        check("t1_stage_hold", 32'(stage_rst_n), 32'hF);
        stage_ack = 4'b0001;
        step(3);

        // ---------------- Test 3: warm reset from DONE
        sw_req = 1'b1;
        step(1);                         // entry edge E
        sw_req = 1'b0;
        check("t3_e0", 32'(stage_rst_n), 32'h7);
        check("t3_busy", 32'(busy), 32'h1);
        step(15);
        check("t3_e15", 32'(stage_rst_n), 32'h7);
        step(1);
        check("t3_e16", 32'(stage_rst_n), 32'h3);
        step(16);
        check("t3_e32", 32'(stage_rst_n), 32'h1);
        step(15);
        check("t3_e47", 32'(stage_rst_n), 32'h1);
        step(1);
        check("t3_e48", 32'(stage_rst_n), 32'h0);
        k = 0;
        while (stage_rst_n[0] !== 1'b1 && k < 200) begin
            step(1);
            k++;
        end
        check("t3_restart_s0", 32'(stage_rst_n), 32'h1);
        check("t3_restart_late", 32'(k > 40), 32'h1);
        k = 0;
        while (stage_rst_n !== 4'b0111 && k < 200) begin
            step(1);
            k++;
        end
        check("t3_restart_s2", 32'(stage_rst_n), 32'h7);

        // ---------------- Test 4: one-cycle pad reset mid-GAP of stage 2
        step(5);
        ext_rst_n = 1'b0;
        step(1);                         // edge a
        ext_rst_n = 1'b1;
        step(2);                         // edge a+2
        check("t4_stage", 32'(stage_rst_n), 32'h0);
        check("t4_idx", 32'(idx), 32'h0);
        check("t4_busy", 32'(busy), 32'h1);
        check("t4_done", 32'(done), 32'h0);
        step(64);                        // edge a+66
        check("t4_s0_before", 32'(stage_rst_n), 32'h0);
        step(1);                         // edge a+67
        check("t4_s0_rise", 32'(stage_rst_n), 32'h1);

        // ---------------- Test 7: ack arrives on the timeout compare cycle
        rst_n = 1'b0;
        stage_ack = 4'b0000;
        step(2);
        check_reset_vals("t7_rst");
        rst_n = 1'b1;
        step(1088);
        stage_ack = 4'b0001;             // sync'd value seen at edge 1091
        step(2);                         // edge 1090
        check("t7_tmo_1090", 32'(tmo), 32'h0);
        check("t7_stage_1090", 32'(stage_rst_n), 32'h1);
        step(1);                         // edge 1091
        check("t7_tmo_1091", 32'(tmo), 32'h0);
        step(16);                        // edge 1107
        check("t7_s1_before", 32'(stage_rst_n), 32'h1);
        step(1);                         // edge 1108
        check("t7_s1_rise", 32'(stage_rst_n), 32'h3);
        check("t7_tmo_after", 32'(tmo), 32'h0);

        // ---------------- Test 2: ack never arrives -> FAULT
        rst_n = 1'b0;
        stage_ack = 4'b0000;
        step(2);
        rst_n = 1'b1;
        step(1090);
        check("t2_tmo_1090", 32'(tmo), 32'h0);
        step(1);                         // edge 1091
        check("t2_tmo_1091", 32'(tmo), 32'h1);
        check("t2_stage", 32'(stage_rst_n), 32'h1);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_done", 32'(done), 32'h0);
        step(20);
        check("t2_frozen_stage", 32'(stage_rst_n), 32'h1);
        check("t2_frozen_idx", 32'(idx), 32'h0);
        sw_req = 1'b1;
        step(1);                         // entry edge F
        sw_req = 1'b0;
        check("t2_assert_idx", 32'(idx), 32'h3);
        check("t2_assert_e0", 32'(stage_rst_n), 32'h1);
        step(47);
        check("t2_assert_e47", 32'(stage_rst_n), 32'h1);
        step(1);
        check("t2_assert_e48", 32'(stage_rst_n), 32'h0);
        check("t2_tmo_sticky", 32'(tmo), 32'h1);
        k = 0;
        while (stage_rst_n[0] !== 1'b1 && k < 200) begin
            step(1);
            k++;
        end
        check("t2_restart_s0", 32'(stage_rst_n), 32'h1);
        check("t2_tmo_kept", 32'(tmo), 32'h1);

        // ---------------- Test 6: POR reset mid-sequence (async)
        step(3);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("t6");

        // ---------------- Test 5: pad reset toggling every 30 cycles
        ext_rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ext_rst_n = ~ext_rst_n;
            step(30);
            check("t5_no_release", 32'(stage_rst_n), 32'h0);
        end
        ext_rst_n = 1'b1;
        step(66);
        check("t5_final_before", 32'(stage_rst_n), 32'h0);
        step(1);
        check("t5_final_rise", 32'(stage_rst_n), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
